// File: rtl/hilo_muldiv_pkg.sv
// HI/LO multiply/divide unit: shared op and state encodings.
// Imported by the sequencer and its step datapath.
package hilo_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_div(op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_step.sv
// One iteration of shift-add multiply or restoring divide.
// Accumulator is {hi_acc, lo_acc}; m is multiplicand or divisor.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_acc,
  input  logic [WIDTH-1:0] lo_acc,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, m} : '0);
    rem = {hi_acc, lo_acc[WIDTH-1]};
    ge  = rem >= {1'b0, m};
    // When ge holds the true difference is below m, so W bits suffice.
    diff = rem[WIDTH-1:0] - m;
    if (is_div) begin
      hi_next = ge ? diff : rem[WIDTH-1:0];
      lo_next = {lo_acc[WIDTH-2:0], ge};
    end else begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO registers with a one-bit-per-cycle multiply/divide engine.
// Magnitudes are iterated; signs are applied in the FIX state.
module hilo_muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             HIin,
  input  logic             LOin,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import hilo_muldiv_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic             div_r;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] a_r;
  logic [CW-1:0]    cnt;

  op_e              op_in;
  logic             div_in;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic               zdiv;

  assign op_in  = op_e'(op);
  assign div_in = op_is_div(op_in);
  assign sa     = op_is_signed(op_in) & a[WIDTH-1];
  assign sb     = op_is_signed(op_in) & b[WIDTH-1];
  assign mag_a  = sa ? -a : a;
  assign mag_b  = sb ? -b : b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (div_r),
    .hi_acc  (acc_hi),
    .lo_acc  (acc_lo),
    .m       (m_r),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  always_comb begin
    prod   = {acc_hi, acc_lo};
    prod_s = neg_q ? -prod : prod;
    quot_s = neg_q ? -acc_lo : acc_lo;
    rem_s  = neg_r ? -acc_hi : acc_hi;
    zdiv   = (m_r == '0);
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state  <= S_IDLE;
      div_r  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      m_r    <= '0;
      a_r    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dz     <= 1'b0;
      err    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (HIin) hi <= wdata;
          if (LOin) lo <= wdata;
          if (start) begin
            if (div_in && !DIV_EN) begin
              err <= 1'b1;
            end else begin
              div_r  <= div_in;
              neg_q  <= sa ^ sb;
              neg_r  <= sa;
              acc_hi <= '0;
              acc_lo <= mag_a;
              m_r    <= mag_b;
              a_r    <= a;
              cnt    <= '0;
              dz     <= 1'b0;
              busy   <= 1'b1;
              state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          if (!div_r) begin
            hi <= prod_s[2*WIDTH-1:WIDTH];
            lo <= prod_s[WIDTH-1:0];
          end else if (zdiv) begin
            hi <= a_r;
            lo <= '1;
            dz <= 1'b1;
          end else begin
            hi <= rem_s;
            lo <= quot_s;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
